// File: rtl/alu_rr_arbiter_if.sv
// Request/response channels of both requesters plus the shared-ALU side of
// alu_rr_arbiter, bundled so the arbiter and its environment share one port.
interface alu_rr_arbiter_if;

    // Requester 0 request/response channel
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_opcode;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        resp0_valid;
    logic        resp0_ready;
    logic [15:0] resp0_result;
    logic        resp0_err;

    // Requester 1 request/response channel
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_opcode;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [15:0] resp1_result;
    logic        resp1_err;

    // Shared multi-cycle ALU
    logic        alu_start;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        alu_done;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, resp0_ready,
        output req0_ready, resp0_valid, resp0_result, resp0_err,
        input  req1_valid, req1_opcode, req1_a, req1_b, resp1_ready,
        output req1_ready, resp1_valid, resp1_result, resp1_err,
        output alu_start, alu_opcode, alu_a, alu_b,
        input  alu_result, alu_done
    );

    // Environment side: requesters and the ALU itself
    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, resp0_ready,
        input  req0_ready, resp0_valid, resp0_result, resp0_err,
        output req1_valid, req1_opcode, req1_a, req1_b, resp1_ready,
        input  req1_ready, resp1_valid, resp1_result, resp1_err,
        input  alu_start, alu_opcode, alu_a, alu_b,
        output alu_result, alu_done
    );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer in front of one shared
// multi-cycle 16-bit ALU. One op is in flight at a time: accept, issue a
// single start pulse, wait for done (bounded by TIMEOUT cycles), then hold the
// response until the winning requester takes it. Illegal opcodes and divide by
// zero are answered directly with err = 1 and never reach the ALU.
// TIMEOUT must lie in 2..255 and fit in CNT_W bits.
module alu_rr_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    alu_rr_arbiter_if.slave bus
);

    localparam logic [2:0]       OP_DIV   = 3'b011;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e state_q, state_d;

    logic             last_grant_q, last_grant_d;  // id granted most recently
    logic             grant_q, grant_d;            // id owning the op in flight
    logic [2:0]       op_q, op_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      result_q, result_d;
    logic             err_q, err_d;

    logic        win;
    logic        any_valid;
    logic        accept;
    logic [2:0]  sel_opcode;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic        sel_illegal;
    logic        resp_taken;
    logic        timeout_hit;

    // Pick the winner among pending requests and screen the winning op
    // NOTE: every signal gets a default at the top of each always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        win = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            win = ~last_grant_q;
        end else if (bus.req1_valid) begin
            win = 1'b1;
        end
        any_valid   = bus.req0_valid || bus.req1_valid;
        accept      = (state_q == S_IDLE) && any_valid;
        sel_opcode  = win ? bus.req1_opcode : bus.req0_opcode;
        sel_a       = win ? bus.req1_a      : bus.req0_a;
        sel_b       = win ? bus.req1_b      : bus.req0_b;
        sel_illegal = sel_opcode[2] || ((sel_opcode == OP_DIV) && (sel_b == 16'h0000));
        resp_taken  = grant_q ? bus.resp1_ready : bus.resp0_ready;
        timeout_hit = (cnt_q == CNT_LAST);
    end

    // State register
    // NOTE: reset is asynchronous so an op in flight is abandoned the moment
    // reset rises, without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = sel_illegal ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = bus.alu_done ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // alu_done wins over a timeout landing in the same cycle
                if (bus.alu_done || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_taken) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: captured op, grant history, timeout counter, response
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the values from before this edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_q         <= 3'b000;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            cnt_q        <= '0;
            result_q     <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    // Datapath next values: capture on accept, count in WAIT, latch the outcome
    always_comb begin
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    last_grant_d = win;
                    grant_d      = win;
                    op_d         = sel_opcode;
                    a_d          = sel_a;
                    b_d          = sel_b;
                    if (sel_illegal) begin
                        result_d = 16'h0000;
                        err_d    = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                if (bus.alu_done) begin
                    result_d = bus.alu_result;
                    err_d    = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.alu_done) begin
                    result_d = bus.alu_result;
                    err_d    = 1'b0;
                end else if (timeout_hit) begin
                    result_d = 16'h0000;
                    err_d    = 1'b1;
                end
            end
            default: begin
                // RESP holds result and err stable until the handshake
            end
        endcase
    end

    // Output decode from state and captured op
    always_comb begin
        // Readys are masked during reset so every output reads 0 while it is held
        bus.req0_ready   = accept && !win && !reset;
        bus.req1_ready   = accept &&  win && !reset;

        bus.resp0_valid  = (state_q == S_RESP) && !grant_q;
        bus.resp1_valid  = (state_q == S_RESP) &&  grant_q;
        bus.resp0_result = bus.resp0_valid ? result_q : 16'h0000;
        bus.resp1_result = bus.resp1_valid ? result_q : 16'h0000;
        bus.resp0_err    = bus.resp0_valid && err_q;
        bus.resp1_err    = bus.resp1_valid && err_q;

        bus.alu_start    = (state_q == S_ISSUE);
        bus.alu_opcode   = op_q;
        bus.alu_a        = a_q;
        bus.alu_b        = b_q;
    end

endmodule
